// File: rtl/pwm_sched_pkg.sv
// rtl/pwm_sched_pkg.sv - shared duty type, full-scale constant and duty-to-on-time helpers
package pwm_sched_pkg;

    typedef logic [6:0] duty_t;

    localparam int unsigned DUTY_FULL = 100;

    // floor(duty*tp/100); callers truncate to their own on-time width
    function automatic int unsigned ton_calc(input duty_t duty, input int unsigned tp);
        int unsigned prod;
        prod = 32'(duty) * tp;
        return prod / DUTY_FULL;
    endfunction

    function automatic duty_t sat_duty(input duty_t duty, input duty_t lo, input duty_t hi);
        if (duty < lo) begin
            return lo;
        end
        if (duty > hi) begin
            return hi;
        end
        return duty;
    endfunction

endpackage

// File: rtl/pwm_duty_sched_rr_arb2.sv
// rtl/pwm_duty_sched_rr_arb2.sv - two-way round-robin arbiter for duty requesters
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // after a transfer, priority passes to the requester that was not served
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/pwm_duty_sched.sv
// rtl/pwm_duty_sched.sv - PWM duty scheduler, boundary-aligned duty updates; PWM_DUTY_CLAMP_EN saturates duties
module pwm_duty_sched
    import pwm_sched_pkg::*;
#(
    parameter int TP       = 10,
    parameter int DUTY_RST = 50,
    parameter int DUTY_MIN = 10,
    parameter int DUTY_MAX = 80
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    input  logic [1:0][6:0] req_duty,
    output logic [1:0]      req_ready,
    output logic [1:0]      req_err,
    output logic            pwm_out,
    output logic            period_start,
    output logic [6:0]      cur_duty,
    output logic            pend_valid
);

    localparam int W  = $clog2(TP + 1);
    localparam int CW = $clog2(TP);
    localparam logic [CW-1:0] CNT_LAST = CW'(TP - 1);
    localparam logic [W-1:0]  TON_RST  = W'(ton_calc(duty_t'(DUTY_RST), TP));

`ifdef PWM_DUTY_CLAMP_EN
    localparam bit    CLAMP_EN = 1'b1;
    localparam duty_t CLAMP_LO = duty_t'(DUTY_MIN);
    localparam duty_t CLAMP_HI = duty_t'(DUTY_MAX);
`else
    // bounds span the whole duty range, so saturation is a pass-through
    localparam bit    CLAMP_EN = 1'b0;
    localparam duty_t CLAMP_LO = duty_t'(DUTY_MIN * 0);
    localparam duty_t CLAMP_HI = duty_t'(127 + DUTY_MAX * 0);
`endif

    logic [CW-1:0] cnt;
    logic [W-1:0]  ton_act;
    logic [W-1:0]  pend_ton;
    duty_t         pend_duty;
    logic [1:0]    grant;
    logic          xfer;
    logic          boundary;
    logic          bad;
    duty_t         sel_duty;
    duty_t         acc_duty;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (xfer),
        .grant   (grant)
    );

    assign req_ready    = pend_valid ? 2'b00 : grant;
    assign xfer         = |(req_valid & req_ready);
    assign boundary     = (cnt == CNT_LAST);
    assign sel_duty     = grant[1] ? req_duty[1] : req_duty[0];
    assign acc_duty     = sat_duty(sel_duty, CLAMP_LO, CLAMP_HI);
    assign bad          = !CLAMP_EN && (sel_duty > duty_t'(DUTY_FULL));
    assign pwm_out      = (W'(cnt) < ton_act);
    assign period_start = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            ton_act    <= TON_RST;
            cur_duty   <= duty_t'(DUTY_RST);
            pend_valid <= 1'b0;
            pend_duty  <= '0;
            pend_ton   <= '0;
            req_err    <= 2'b00;
        end else begin
            cnt     <= boundary ? '0 : cnt + 1'b1;
            req_err <= (xfer && bad) ? grant : 2'b00;
            if (boundary && pend_valid) begin
                ton_act    <= pend_ton;
                cur_duty   <= pend_duty;
                pend_valid <= 1'b0;
            end
            // a transfer needs pend_valid low, so it never collides with the apply above
            if (xfer && !bad) begin
                pend_duty  <= acc_duty;
                pend_ton   <= W'(ton_calc(acc_duty, TP));
                pend_valid <= 1'b1;
            end
        end
    end

endmodule
